irq_rr_arbiter: RTL
===================

# irq_rr_arbiter

Round-robin interrupt arbiter between the peripheral interrupt request lines and the core's trap/CSR logic. It latches request edges into per-source pending bits and masks them with `mie` and the global enable. It selects one winner and presents it to the core through an ack/done handshake, then emits a one-cycle completion pulse to the serviced source. Only one interrupt is in service at a time; there is no nesting.

## Interface
- `N_SRC`, default 32, number of interrupt sources (2..32)
- `ID_W`, default `$clog2(N_SRC)`, width of source index
- `clock`  in  1  system clock
- `INT_RST`  in  1  reset, asynchronous, active-high
- `int_req`  in  N_SRC  peripheral requests, edge-significant (rising edge pends)
- `mie`  in  N_SRC  per-source enable mask
- `gie`  in  1  global interrupt enable (mstatus.MIE)
- `int_ack`  in  1  core has taken the trap for the presented interrupt
- `int_done`  in  1  core executed mret for the in-service interrupt
- `irq`  out  1  interrupt presented to the core
- `mcause`  out  32  `{1'b1, (31-ID_W)'b0, sel}`; valid while `irq` or `busy`
- `int_fin`  out  N_SRC  one-hot, one-cycle completion pulse to the serviced source
- `busy`  out  1  an interrupt is in service

## Operation
- Edge detect: `req_q` registers `int_req`; `pending[i]` is set when `int_req[i] & ~req_q[i]`.
- Pending clear: `pending[sel]` is cleared in the COMPLETE cycle. A new edge on the same source in that cycle wins, and the bit stays set.
- `eligible = pending & mie`, further gated by `gie`.
- Winner: the first set bit of `eligible` scanning upward from `ptr` with wrap at `N_SRC-1 -> 0`. `ptr` is reset to 0 and becomes `sel+1` (mod `N_SRC`) on COMPLETE.
- FSM states: IDLE, REQ, SERVICE, COMPLETE.
  - IDLE: if `gie && |eligible`, latch the winner into `sel` and go to REQ.
  - REQ: `irq=1`, `sel` frozen. If `int_ack`, go to SERVICE. Otherwise, if `!gie` or `!eligible[sel]`, withdraw to IDLE with no `int_fin`.
  - SERVICE: `irq=0`, `busy=1`. On `int_done`, go to COMPLETE.
  - COMPLETE: `int_fin[sel]=1`, `busy=1`, clear `pending[sel]`, update `ptr`, go to IDLE.
- `int_ack` outside REQ and `int_done` outside SERVICE are ignored.
- When `int_ack` and withdraw conditions coincide in REQ, ack wins and the FSM goes to SERVICE.
- Other sources' edges during SERVICE keep accumulating in `pending`; a second edge on a source that is already pending is absorbed.

## Timing
- Reset values: `irq=0`, `busy=0`, `int_fin=0`, `mcause=32'h8000_0000`, `pending=0`, `req_q=0`, `ptr=0`, `sel=0`, state IDLE.
- A request held high through reset pends on the first edge after reset release.
- Request latency: with `int_req[i]` first sampled high at edge k, `pending[i]` is set after k and `irq` is high after k+1. That is 2 cycles, given `gie=1`, `mie[i]=1` and IDLE.
- `int_ack` sampled at edge m: `irq` is low and `busy` is high after m.
- `int_done` sampled at edge d: `int_fin[sel]` is high for the single cycle after d. IDLE is resumed after d+1, and the next `irq` can appear after d+2.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation aborts everything immediately, with no `int_fin` pulse.

## Structure
- Package `irq_pkg`:
  - state enum `irq_state_e` (IDLE, REQ, SERVICE, COMPLETE)
  - `N_SRC_DEF=32`
  - `MCAUSE_INT_BIT=31`
- Sub-module `rr_priority_pick`, purely combinational.
  - Inputs: `eligible`, `ptr`. Outputs: `any`, `idx`.
  - Implemented as rotate, find-first-set, un-rotate.
- The top level holds the edge detect, pending register, FSM, `ptr`/`sel` registers and output decode.

## Test plan
- Reset release with `int_req[3]` held high, `mie=32'h8`, `gie=1`: `irq` rises 2 cycles later, `mcause=32'h8000_0003`. Then `int_ack`, later `int_done`, gives a one-cycle `int_fin=32'h8` and `busy` low the next cycle.
- Simultaneous edges on sources 2 and 5, `ptr=0`: 2 is served first with `ptr=3` after completion, then 5. After that, new edges on 2 and 5 serve 2 first again (`ptr` wrapped past 5 to 6, scan reaches 2 before 5 on wrap).
- Edge on source 7 with `mie[7]=0`: no `irq`. Setting `mie[7]=1` later raises `irq` on the next cycle.
- In REQ, drop `gie` before `int_ack`: `irq` deasserts the next cycle, no `int_fin`, `pending[7]` is kept. Restoring `gie` re-presents source 7.
- New edge on source 1 during SERVICE of source 4: no `irq` until after `int_fin[4]`; then `mcause=32'h8000_0001`.
- Assert `INT_RST` during SERVICE: all outputs return to reset values asynchronously, `pending` is cleared, no `int_fin`.

Source files
------------

// File: rtl/irq_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin interrupt arbiter.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    SERVICE  = 2'd2,
    COMPLETE = 2'd3
  } irq_state_e;

  localparam int unsigned N_SRC_DEF      = 32;
  localparam int unsigned MCAUSE_INT_BIT = 31;

endpackage

// File: rtl/irq_rr_arbiter_pick.sv
// Combinational round-robin pick: rotate by ptr, find lowest set bit, un-rotate.
module rr_priority_pick #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 5
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  int unsigned  sum;

  always_comb begin
    // Shift by N when ptr==0 yields zero, so the wrap term drops out cleanly.
    rot = (eligible >> ptr) | (eligible << (N - 32'(ptr)));
    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = W'(i - 1);
    end
    sum = 32'(ptr) + 32'(off);
    if (sum >= N) sum = sum - N;
    idx = W'(sum);
    any = |eligible;
  end

endmodule

// File: rtl/irq_rr_arbiter.sv
// Round-robin interrupt arbiter: edge-pended requests, ack/done handshake to the core.
module irq_rr_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic             clock,
  input  logic             INT_RST,
  input  logic [N_SRC-1:0] int_req,
  input  logic [N_SRC-1:0] mie,
  input  logic             gie,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             irq,
  output logic [31:0]      mcause,
  output logic [N_SRC-1:0] int_fin,
  output logic             busy
);

  irq_state_e       state;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] sel_oh;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  assign eligible = pending & mie & {N_SRC{gie}};
  assign sel_oh   = {{(N_SRC-1){1'b0}}, 1'b1} << sel;

  rr_priority_pick #(
    .N (N_SRC),
    .W (ID_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_ff @(posedge clock or posedge INT_RST) begin
    if (INT_RST) begin
      state   <= IDLE;
      req_q   <= '0;
      pending <= '0;
      ptr     <= '0;
      sel     <= '0;
    end else begin
      req_q <= int_req;
      // A fresh edge is OR-ed in after the clear so it survives COMPLETE.
      pending <= ((state == COMPLETE) ? (pending & ~sel_oh) : pending)
                 | (int_req & ~req_q);
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            state <= REQ;
          end
        end
        REQ: begin
          // eligible already folds in gie, so one test covers both withdraw causes.
          if (int_ack)             state <= SERVICE;
          else if (!eligible[sel]) state <= IDLE;
        end
        SERVICE: begin
          if (int_done) state <= COMPLETE;
        end
        COMPLETE: begin
          ptr   <= (sel == ID_W'(N_SRC - 1)) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    irq     = (state == REQ);
    busy    = (state == SERVICE) || (state == COMPLETE);
    int_fin = (state == COMPLETE) ? sel_oh : '0;
    mcause  = '0;
    mcause[MCAUSE_INT_BIT] = 1'b1;
    mcause[ID_W-1:0]       = sel;
  end

endmodule
